// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode encodings, flag bit positions and branch-condition helpers.
package cpu_pkg;

   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned FLAG_W   = 4;

   // Flag vector layout is {Z,V,N,C}
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_V = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 0;

   localparam logic [OPCODE_W-1:0] OP_BGT  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_BLT  = 6'b001001;
   localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b001010;
   localparam logic [OPCODE_W-1:0] OP_BNE  = 6'b001011;
   localparam logic [OPCODE_W-1:0] OP_BLE  = 6'b001100;
   localparam logic [OPCODE_W-1:0] OP_BGE  = 6'b001101;
   localparam logic [OPCODE_W-1:0] OP_BLTU = 6'b001110;
   localparam logic [OPCODE_W-1:0] OP_BGEU = 6'b001111;
   localparam logic [OPCODE_W-1:0] OP_RET  = 6'b011100;
   localparam logic [OPCODE_W-1:0] OP_CALL = 6'b011101;
   localparam logic [OPCODE_W-1:0] OP_JMP  = 6'b011110;

   function automatic logic is_cond_branch(input logic [OPCODE_W-1:0] op);
      logic hit;
      case (op)
         OP_BGT, OP_BLT, OP_BEQ, OP_BNE,
         OP_BLE, OP_BGE, OP_BLTU, OP_BGEU: hit = 1'b1;
         default:                          hit = 1'b0;
      endcase
      return hit;
   endfunction

   // Condition of a conditional branch against the registered flags; 0 for other opcodes
   function automatic logic branch_cond(input logic [OPCODE_W-1:0] op,
                                        input logic [FLAG_W-1:0]   f);
      logic lt;
      logic res;
      lt = f[FLAG_N] ^ f[FLAG_V];
      case (op)
         OP_BNE:  res = ~f[FLAG_Z];
         OP_BEQ:  res = f[FLAG_Z];
         OP_BLT:  res = lt;
         OP_BGT:  res = ~f[FLAG_Z] & ~lt;
         OP_BLE:  res = f[FLAG_Z] | lt;
         OP_BGE:  res = ~lt;
         OP_BLTU: res = ~f[FLAG_C];
         OP_BGEU: res = f[FLAG_C];
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Controller-facing bus of the PC/branch unit: decode and ALU inputs in, PC and status out.
interface pc_branch_unit_if #(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned STATE_WIDTH = 4,
   parameter int unsigned RAS_DEPTH   = 4
);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

   logic [5:0]             opcode;
   logic [STATE_WIDTH-1:0] state;
   logic                   aluZ;
   logic                   aluV;
   logic                   aluN;
   logic                   aluC;
   logic                   flagWrite;
   logic                   pcWriteUncond;
   logic [PC_WIDTH-1:0]    branchTarget;
   logic [PC_WIDTH-1:0]    jumpTarget;

   logic [PC_WIDTH-1:0]    pc;
   logic                   writeEn;
   logic                   branchTaken;
   logic [3:0]             flags;
   logic [CNT_W-1:0]       rasCount;
   logic                   rasOverflow;
   logic                   rasUnderflow;

   modport master (
      output opcode, state, aluZ, aluV, aluN, aluC, flagWrite, pcWriteUncond,
             branchTarget, jumpTarget,
      input  pc, writeEn, branchTaken, flags, rasCount, rasOverflow, rasUnderflow
   );

   modport slave (
      input  opcode, state, aluZ, aluV, aluN, aluC, flagWrite, pcWriteUncond,
             branchTarget, jumpTarget,
      output pc, writeEn, branchTaken, flags, rasCount, rasOverflow, rasUnderflow
   );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry;
// overflow/underflow are sticky until reset.
module ras_stack #(
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push_i,
   input  logic                            pop_i,
   input  logic [PC_WIDTH-1:0]             push_data_i,
   output logic [PC_WIDTH-1:0]             top_o,
   output logic [$clog2(RAS_DEPTH):0]      count_o,
   output logic                            overflow_o,
   output logic                            underflow_o
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]    sp_q, sp_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                full;
   logic                empty;

   assign full  = (count_q == CNT_W'(RAS_DEPTH));
   assign empty = (count_q == '0);

   // sp points at the next free slot; the top entry sits just below it
   always_comb begin
      sp_d    = sp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (push_i) begin
         sp_d = PTR_W'(sp_q + PTR_W'(1));
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            count_d = CNT_W'(count_q + CNT_W'(1));
         end
      end else if (pop_i) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            sp_d    = PTR_W'(sp_q - PTR_W'(1));
            count_d = CNT_W'(count_q - CNT_W'(1));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Entry storage is not reset; count gates its validity
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[sp_q] <= push_data_i;
      end
   end

   assign top_o       = mem_q[PTR_W'(sp_q - PTR_W'(1))];
   assign count_o     = count_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with registered ALU flags, conditional branch resolution,
// jumps and call/return through a return-address stack.
module pc_branch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned PC_WIDTH     = 32,
   parameter int unsigned RAS_DEPTH    = 4,
   parameter int unsigned STATE_WIDTH  = 4,
   parameter int unsigned BRANCH_STATE = 7,
   parameter int unsigned JUMP_STATE   = 2,
   parameter int unsigned PC_STEP      = 1,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   pc_branch_unit_if.slave    bus
);

   localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;

   logic                in_branch;
   logic                in_jump;
   logic                is_jmp;
   logic                is_call;
   logic                is_ret;
   logic                branch_taken_c;
   logic                jump_event_c;
   logic                ras_push;
   logic                ras_pop;
   logic [PC_WIDTH-1:0] ras_top;
   logic [CNT_W-1:0]    ras_count;
   logic                ras_ovf;
   logic                ras_unf;
   logic                ras_empty;

   assign in_branch = (bus.state == STATE_WIDTH'(BRANCH_STATE));
   assign in_jump   = (bus.state == STATE_WIDTH'(JUMP_STATE));
   assign is_jmp    = (bus.opcode == OP_JMP);
   assign is_call   = (bus.opcode == OP_CALL);
   assign is_ret    = (bus.opcode == OP_RET);
   assign ras_empty = (ras_count == '0);

   // Conditions see only the registered flags, never this cycle's ALU outputs
   assign branch_taken_c = in_branch && is_cond_branch(bus.opcode)
                           && branch_cond(bus.opcode, flags_q);
   assign jump_event_c   = in_jump && (is_jmp || is_call || (is_ret && !ras_empty));

   assign ras_push = in_jump && is_call;
   assign ras_pop  = in_jump && is_ret;

   always_comb begin
      flags_d = flags_q;
      if (bus.flagWrite) begin
         flags_d[FLAG_Z] = bus.aluZ;
         flags_d[FLAG_V] = bus.aluV;
         flags_d[FLAG_N] = bus.aluN;
         flags_d[FLAG_C] = bus.aluC;
      end
   end

   // Next-PC priority: branch, jump/call, return, fetch increment, hold
   always_comb begin
      pc_d = pc_q;
      if (branch_taken_c) begin
         pc_d = bus.branchTarget;
      end else if (in_jump && (is_jmp || is_call)) begin
         pc_d = bus.jumpTarget;
      end else if (in_jump && is_ret && !ras_empty) begin
         pc_d = ras_top;
      end else if (bus.pcWriteUncond) begin
         pc_d = PC_WIDTH'(pc_q + PC_WIDTH'(PC_STEP));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         flags_q <= '0;
      end else begin
         pc_q    <= pc_d;
         flags_q <= flags_d;
      end
   end

   ras_stack #(
      .PC_WIDTH  (PC_WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (ras_push),
      .pop_i       (ras_pop),
      .push_data_i (pc_q),
      .top_o       (ras_top),
      .count_o     (ras_count),
      .overflow_o  (ras_ovf),
      .underflow_o (ras_unf)
   );

   assign bus.pc           = pc_q;
   assign bus.flags        = flags_q;
   assign bus.writeEn      = branch_taken_c | jump_event_c | bus.pcWriteUncond;
   assign bus.branchTaken  = branch_taken_c;
   assign bus.rasCount     = ras_count;
   assign bus.rasOverflow  = ras_ovf;
   assign bus.rasUnderflow = ras_unf;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed and randomized checks of pc_branch_unit against a queue-based reference model.
module tb_pc_branch_unit;

   localparam logic [5:0] BGT  = 6'b001000;
   localparam logic [5:0] BLT  = 6'b001001;
   localparam logic [5:0] BEQ  = 6'b001010;
   localparam logic [5:0] BNE  = 6'b001011;
   localparam logic [5:0] BLE  = 6'b001100;
   localparam logic [5:0] BGE  = 6'b001101;
   localparam logic [5:0] BLTU = 6'b001110;
   localparam logic [5:0] BGEU = 6'b001111;
   localparam logic [5:0] RET  = 6'b011100;
   localparam logic [5:0] CALL = 6'b011101;
   localparam logic [5:0] JMP  = 6'b011110;
   localparam logic [5:0] NOP  = 6'b000000;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pc_branch_unit_if #(.PC_WIDTH(32), .STATE_WIDTH(4), .RAS_DEPTH(DEPTH)) bus ();

   pc_branch_unit #(
      .PC_WIDTH(32), .RAS_DEPTH(DEPTH), .STATE_WIDTH(4),
      .BRANCH_STATE(7), .JUMP_STATE(2), .PC_STEP(1), .RESET_PC(32'h0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [3:0]  m_fl;
   logic [31:0] m_ras[$];
   logic        m_ovf;
   logic        m_unf;

   logic [5:0] ops [14] = '{BGT, BLT, BEQ, BNE, BLE, BGE, BLTU, BGEU,
                            RET, CALL, JMP, RET, NOP, 6'h3f};

   function automatic logic cond_holds(input logic [5:0] op, input logic [3:0] f);
      logic z, v, n, c;
      z = f[3]; v = f[2]; n = f[1]; c = f[0];
      case (op)
         BNE:     return !z;
         BEQ:     return z;
         BLT:     return n != v;
         BGT:     return !z && (n == v);
         BLE:     return z || (n != v);
         BGE:     return n == v;
         BLTU:    return !c;
         BGEU:    return c;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [3:0] st, input logic [3:0] zvnc,
                        input logic fw, input logic unc,
                        input logic [31:0] bt, input logic [31:0] jt);
      bus.opcode        = op;
      bus.state         = st;
      bus.aluZ          = zvnc[3];
      bus.aluV          = zvnc[2];
      bus.aluN          = zvnc[1];
      bus.aluC          = zvnc[0];
      bus.flagWrite     = fw;
      bus.pcWriteUncond = unc;
      bus.branchTarget  = bt;
      bus.jumpTarget    = jt;
   endtask

   task automatic idle();
      drive(NOP, 4'd0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic model_reset();
      m_pc  = 32'h0;
      m_fl  = 4'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".pc"},           64'(bus.pc),           64'(m_pc));
      chk({tag, ".flags"},        64'(bus.flags),        64'(m_fl));
      chk({tag, ".rasCount"},     64'(bus.rasCount),     64'(m_ras.size()));
      chk({tag, ".rasOverflow"},  64'(bus.rasOverflow),  64'(m_ovf));
      chk({tag, ".rasUnderflow"}, 64'(bus.rasUnderflow), 64'(m_unf));
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs
   task automatic step(input string tag);
      logic bt, jmpcall, ret_ok, we;
      #1;
      bt      = (bus.state == 4'd7) && cond_holds(bus.opcode, m_fl);
      jmpcall = (bus.state == 4'd2) && (bus.opcode == JMP || bus.opcode == CALL);
      ret_ok  = (bus.state == 4'd2) && (bus.opcode == RET) && (m_ras.size() > 0);
      we      = bt || jmpcall || ret_ok || bus.pcWriteUncond;
      chk({tag, ".branchTaken"}, 64'(bus.branchTaken), 64'(bt));
      chk({tag, ".writeEn"},     64'(bus.writeEn),     64'(we));

      if ((bus.state == 4'd2) && (bus.opcode == CALL)) begin
         if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
         end
         m_ras.push_back(m_pc);
      end
      if ((bus.state == 4'd2) && (bus.opcode == RET) && (m_ras.size() == 0)) m_unf = 1'b1;

      if (bt)                       m_pc = bus.branchTarget;
      else if (jmpcall)             m_pc = bus.jumpTarget;
      else if (ret_ok)              m_pc = m_ras.pop_back();
      else if (bus.pcWriteUncond)   m_pc = m_pc + 32'd1;
      if (bus.flagWrite) m_fl = {bus.aluZ, bus.aluV, bus.aluN, bus.aluC};

      @(posedge clk);
      #1;
      check_regs(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      #2;
      check_regs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Fetch increments
      chk("fetch.pc0", 64'(bus.pc), 64'd0);
      for (int i = 0; i < 3; i++) begin
         drive(NOP, 4'd0, 4'h0, 1'b0, 1'b1, 32'h0, 32'h0);
         step("fetch");
      end
      chk("fetch.pc3", 64'(bus.pc), 64'd3);

      // Signed less-than taken, greater-or-equal not taken
      drive(NOP, 4'd0, 4'b0010, 1'b1, 1'b0, 32'h0, 32'h0);
      step("flagwr_n");
      drive(BLT, 4'd7, 4'h0, 1'b0, 1'b0, 32'h40, 32'h0);
      step("blt");
      chk("blt.pc", 64'(bus.pc), 64'h40);
      drive(BGE, 4'd7, 4'h0, 1'b0, 1'b0, 32'h80, 32'h0);
      step("bge");
      chk("bge.pc", 64'(bus.pc), 64'h40);

      // Taken branch beats fetch increment
      drive(NOP, 4'd0, 4'b0001, 1'b1, 1'b0, 32'h0, 32'h0);
      step("flagwr_c");
      drive(BGEU, 4'd7, 4'h0, 1'b0, 1'b1, 32'h100, 32'h0);
      step("bgeu");
      chk("bgeu.pc", 64'(bus.pc), 64'h100);

      // Five calls into a four-deep stack
      drive(JMP, 4'd2, 4'h0, 1'b0, 1'b0, 32'h0, 32'h10);
      step("jmp");
      for (int i = 0; i < 5; i++) begin
         drive(CALL, 4'd2, 4'h0, 1'b0, 1'b0, 32'h0, 32'((i + 2) * 16));
         step("call");
      end
      chk("calls.ovf",   64'(bus.rasOverflow), 64'd1);
      chk("calls.count", 64'(bus.rasCount),    64'd4);
      for (int i = 0; i < 4; i++) begin
         drive(RET, 4'd2, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
         step("ret");
         chk("ret.pc", 64'(bus.pc), 64'(32'h50 - 32'(i * 16)));
      end

      // Return with empty stack
      drive(RET, 4'd2, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step("ret_empty");
      chk("ret_empty.pc",  64'(bus.pc),           64'h20);
      chk("ret_empty.unf", 64'(bus.rasUnderflow), 64'd1);

      // Reset asserted mid-cycle during a CALL
      drive(CALL, 4'd2, 4'h0, 1'b0, 1'b0, 32'h0, 32'h99);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_regs("rst_mid");
      @(posedge clk);
      #1;
      check_regs("rst_hold");
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      step("rst_after");

      // Randomized phase
      for (int i = 0; i < 400; i++) begin
         logic [3:0] st;
         case ($urandom_range(0, 2))
            0:       st = 4'd2;
            1:       st = 4'd7;
            default: st = 4'($urandom_range(0, 15));
         endcase
         drive(ops[$urandom_range(0, 13)], st, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
